id_ex_stage: RTL and testbench

Decode-to-execute pipeline register with integrated load-use hazard control. Captures the decoded instruction from ID each cycle and presents `ex_*` fields (op_code, rs, rt, dest, operands) to the EX stage and the forwarding unit. Detects load-use dependencies that forwarding cannot cover, inserts a one-cycle bubble and stalls ID. Also honours downstream hold and branch flush, including a flush that arrives while the stage is held.

---
 rtl/id_ex_stage_pkg.sv | 22 ++
 rtl/id_ex_stage_hazard_detect.sv | 32 +++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: opcode encodings shared by the decode/execute boundary
// and a helper that tells whether an opcode reads its rt operand.
package id_ex_stage_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
  localparam logic [OP_W-1:0] OP_LW   = 6'd3;
  localparam logic [OP_W-1:0] OP_SW   = 6'd4;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd5;

  // Register-register ALU ops and stores consume rt; immediates and loads do not.
  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SW: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: purely combinational load-use detector. Flags an ID-stage
// instruction that needs a value still being loaded by the EX-stage
// instruction. Register index 0 is hard-wired and never creates a hazard.
// Written against generic ex/id fields so the IF/ID stage can reuse it.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic             id_valid_i,
  input  logic [OP_W-1:0]  id_op_code_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);

  logic rs_match_s;
  logic rt_match_s;
  logic ex_load_s;

  // Compare the pending load destination against the sources ID will read.
  always_comb begin
    ex_load_s  = ex_valid_i & ex_mem_read_i & (ex_dest_i != '0);
    rs_match_s = (ex_dest_i == id_rs_i);
    rt_match_s = uses_rt(id_op_code_i) & (ex_dest_i == id_rt_i);
    load_use_o = ex_load_s & id_valid_i & (rs_match_s | rt_match_s);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion,
// downstream hold and branch flush (a flush seen while held is remembered
// and applied on the first unheld edge).
// Optional build macro: HAZARD_STATS_EN adds the saturating lu_bubble_cnt.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_op_code,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_arg1,
  input  logic [DATA_W-1:0] id_arg2,
  input  logic [DATA_W-1:0] id_store_val,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [5:0]        ex_op_code,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dest,
  output logic [DATA_W-1:0] ex_arg1,
  output logic [DATA_W-1:0] ex_arg2,
  output logic [DATA_W-1:0] ex_store_val
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       lu_bubble_cnt
`endif
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic [5:0]        op_code_q, op_code_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [DATA_W-1:0] arg1_q, arg1_d, arg2_q, arg2_d, store_val_q, store_val_d;
  logic              flush_pend_q, flush_pend_d;
  logic              flush_eff_s;
  logic              load_use_s;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (mem_read_q),
    .ex_dest_i     (dest_q),
    .id_valid_i    (id_valid),
    .id_op_code_i  (id_op_code),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .load_use_o    (load_use_s)
  );

  // Flush bookkeeping and the ID stall request (flush cancels the stall).
  always_comb begin
    flush_eff_s  = flush | flush_pend_q;
    flush_pend_d = ex_hold ? (flush_pend_q | flush) : 1'b0;
    stall_id     = ex_hold | (load_use_s & ~flush_eff_s);
  end

  // Next EX contents: hold, bubble (flush or load-use), or capture ID.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    op_code_d   = op_code_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    store_val_d = store_val_q;
    if (ex_hold) begin
      valid_d = valid_q;
    end else if (flush_eff_s | load_use_s) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      op_code_d   = OP_NOP;
      rs_d        = '0;
      rt_d        = '0;
      dest_d      = '0;
      arg1_d      = '0;
      arg2_d      = '0;
      store_val_d = '0;
    end else begin
      valid_d     = id_valid;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      op_code_d   = id_op_code;
      rs_d        = id_rs;
      rt_d        = id_rt;
      dest_d      = id_dest;
      arg1_d      = id_arg1;
      arg2_d      = id_arg2;
      store_val_d = id_store_val;
    end
  end

  // Pipeline register and pending-flush flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      op_code_q    <= OP_NOP;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      arg1_q       <= '0;
      arg2_q       <= '0;
      store_val_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      op_code_q    <= op_code_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      store_val_q  <= store_val_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_op_code   = op_code_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_dest      = dest_q;
  assign ex_arg1      = arg1_q;
  assign ex_arg2      = arg2_q;
  assign ex_store_val = store_val_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Count edges where a load-use bubble is actually loaded; saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!ex_hold && !flush_eff_s && load_use_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Bubble counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lu_bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_op_code;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_reg_write, id_mem_read;
  logic [31:0] id_arg1, id_arg2, id_store_val;
  logic        ex_hold, flush;
  logic        stall_id;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [5:0]  ex_op_code;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [31:0] ex_arg1, ex_arg2, ex_store_val;
`ifdef HAZARD_STATS_EN
  logic [15:0] lu_bubble_cnt;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_op_code   (id_op_code),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_arg1      (id_arg1),
    .id_arg2      (id_arg2),
    .id_store_val (id_store_val),
    .ex_hold      (ex_hold),
    .flush        (flush),
    .stall_id     (stall_id),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_op_code   (ex_op_code),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dest      (ex_dest),
    .ex_arg1      (ex_arg1),
    .ex_arg2      (ex_arg2),
    .ex_store_val (ex_store_val)
`ifdef HAZARD_STATS_EN
    ,
    .lu_bubble_cnt(lu_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] dst, input logic rw,
                        input logic mr, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] sv);
    id_valid = v; id_op_code = op; id_rs = rs; id_rt = rt; id_dest = dst;
    id_reg_write = rw; id_mem_read = mr; id_arg1 = a1; id_arg2 = a2; id_store_val = sv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    set_id(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #12;
    check_eq("rst_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_op", {26'd0, ex_op_code}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r3 <- r1, r2
    set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h11, 32'h22, 32'h33);
    tick();
    check_eq("add_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("add_dest", {27'd0, ex_dest}, 32'd3);
    check_eq("add_op", {26'd0, ex_op_code}, {26'd0, OP_ADD});
    check_eq("add_rs_rt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd1, 5'd2});
    check_eq("add_arg2", ex_arg2, 32'h22);
    check_eq("add_sv", ex_store_val, 32'h33);
    check_eq("add_rw_mr", {30'd0, ex_reg_write, ex_mem_read}, 32'd2);
    check_eq("add_stall", {31'd0, stall_id}, 32'd0);

    // LW r5, then dependent ADD rs=5
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h40, 32'd0, 32'd0);
    tick();
    check_eq("lw_mr", {31'd0, ex_mem_read}, 32'd1);
    set_id(1'b1, OP_ADD, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'h55, 32'h66, 32'd0);
    #1;
    check_eq("lu_stall", {31'd0, stall_id}, 32'd1);
    tick();
    check_eq("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("lu_bubble_dest", {27'd0, ex_dest}, 32'd0);
    check_eq("lu_bubble_arg1", ex_arg1, 32'd0);
    check_eq("lu_stall_gone", {31'd0, stall_id}, 32'd0);
`ifdef HAZARD_STATS_EN
    check_eq("lu_cnt", {16'd0, lu_bubble_cnt}, 32'd1);
`endif
    tick();
    check_eq("lu_add_in", {26'd0, ex_valid, ex_dest}, {26'd0, 1'b1, 5'd7});
    check_eq("lu_add_arg1", ex_arg1, 32'h55);

    // LW r0 followed by ADD rs=0: no hazard
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    tick();
    set_id(1'b1, OP_ADD, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    check_eq("r0_stall", {31'd0, stall_id}, 32'd0);
    tick();
    check_eq("r0_add_in", {26'd0, ex_valid, ex_dest}, {26'd0, 1'b1, 5'd8});

    // LW r4 then SW rt=4: hazard via rt
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    tick();
    set_id(1'b1, OP_SW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h99);
    #1;
    check_eq("sw_rt_stall", {31'd0, stall_id}, 32'd1);
    tick();
    check_eq("sw_bubble", {31'd0, ex_valid}, 32'd0);
    // LW r4 then ADDI with rt=4: rt not read, no hazard
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    tick();
    set_id(1'b1, OP_ADDI, 5'd1, 5'd4, 5'd9, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    check_eq("addi_stall", {31'd0, stall_id}, 32'd0);
    tick();
    check_eq("addi_in", {26'd0, ex_valid, ex_dest}, {26'd0, 1'b1, 5'd9});

    // Hold for 3 edges with a flush pulse in the first held cycle
    set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'hA, 32'hB, 32'd0);
    tick();
    set_id(1'b1, OP_SUB, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 32'hC, 32'hD, 32'd0);
    ex_hold = 1'b1; flush = 1'b1;
    #1;
    check_eq("hold_stall0", {31'd0, stall_id}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      flush = 1'b0;
      check_eq("hold_dest", {26'd0, ex_valid, ex_dest}, {26'd0, 1'b1, 5'd10});
      check_eq("hold_arg1", ex_arg1, 32'hA);
      check_eq("hold_stall", {31'd0, stall_id}, 32'd1);
    end
    ex_hold = 1'b0;
    #1;
    check_eq("unhold_stall", {31'd0, stall_id}, 32'd0);
    tick();
    check_eq("pend_bubble", {26'd0, ex_valid, ex_dest}, 32'd0);
    tick();
    check_eq("pend_cleared", {26'd0, ex_valid, ex_dest}, {26'd0, 1'b1, 5'd11});

    // Load-use and flush together: flush wins, no stall
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd12, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
    tick();
    set_id(1'b1, OP_ADD, 5'd12, 5'd2, 5'd13, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    flush = 1'b1;
    #1;
    check_eq("lu_flush_stall", {31'd0, stall_id}, 32'd0);
    tick();
    flush = 1'b0;
    check_eq("lu_flush_bubble", {26'd0, ex_valid, ex_dest}, 32'd0);
`ifdef HAZARD_STATS_EN
    check_eq("lu_flush_cnt", {16'd0, lu_bubble_cnt}, 32'd2);
`endif

    // Reset while a flush is pending
    set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 32'h7, 32'd0, 32'd0);
    tick();
    ex_hold = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; ex_hold = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", {26'd0, ex_valid, ex_dest}, 32'd0);
    check_eq("rst_mid_arg1", ex_arg1, 32'd0);
    check_eq("rst_mid_stall", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd15, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    check_eq("rst_no_residual", {26'd0, ex_valid, ex_dest}, {26'd0, 1'b1, 5'd15});

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
